input_module_vc: RTL and testbench

//  Router input port with per-virtual-channel flit buffering and XY route computation.

---
 rtl/ravenoc_pkg.sv | 39 +++
 rtl/vc_flit_fifo.sv | 49 ++++
 rtl/input_module_vc.sv | 139 +++++++++++++
 tb/tb_input_module_vc.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ravenoc_pkg.sv
// Shared ravenoc types: flit encoding, one-hot router ports and the XY route helper.
package ravenoc_pkg;

  localparam int XWidth       = 2;
  localparam int YWidth       = 2;
  localparam int DefNVirtChn  = 2;
  localparam int DefBuffDepth = 4;

  typedef enum logic [1:0] {
    HEAD_FLIT      = 2'b00,
    BODY_FLIT      = 2'b01,
    TAIL_FLIT      = 2'b10,
    HEAD_TAIL_FLIT = 2'b11
  } flit_type_t;

  typedef enum logic [4:0] {
    PORT_NONE  = 5'b00000,
    NORTH_PORT = 5'b00001,
    SOUTH_PORT = 5'b00010,
    WEST_PORT  = 5'b00100,
    EAST_PORT  = 5'b01000,
    LOCAL_PORT = 5'b10000
  } router_port_t;

  // Dimension-ordered routing: resolve X completely before moving in Y.
  function automatic router_port_t xy_route(input logic [XWidth-1:0] x_dest,
                                            input logic [YWidth-1:0] y_dest,
                                            input logic [XWidth-1:0] x_id,
                                            input logic [YWidth-1:0] y_id);
    router_port_t port;
    if (x_dest > x_id)      port = EAST_PORT;
    else if (x_dest < x_id) port = WEST_PORT;
    else if (y_dest > y_id) port = SOUTH_PORT;
    else if (y_dest < y_id) port = NORTH_PORT;
    else                    port = LOCAL_PORT;
    return port;
  endfunction

endpackage

// File: rtl/vc_flit_fifo.sv
// Per-VC flit FIFO with fall-through read: the head flit is visible on rd_data_o while not empty.
module vc_flit_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en_i);
    rd_ptr_d = rd_ptr_q + AW'(rd_en_i);
    count_d  = count_q + (AW+1)'(wr_en_i) - (AW+1)'(rd_en_i);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/input_module_vc.sv
// Router input port: per-VC flit buffering, per-VC wormhole route latching and
// round-robin VC arbitration onto a single flit-per-cycle output.
module input_module_vc
  import ravenoc_pkg::*;
#(
  parameter int FLIT_WIDTH  = 34,
  parameter int N_VIRT_CHN  = DefNVirtChn,
  parameter int BUFF_DEPTH  = DefBuffDepth,
  parameter int ROUTER_X_ID = 0,
  parameter int ROUTER_Y_ID = 0,
  localparam int VC_W = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  fin_valid_i,
  input  logic [FLIT_WIDTH-1:0] fin_data_i,
  input  logic [VC_W-1:0]       fin_vc_id_i,
  output logic [N_VIRT_CHN-1:0] fin_ready_o,
  output logic                  fout_valid_o,
  output logic [FLIT_WIDTH-1:0] fout_data_o,
  output logic [VC_W-1:0]       fout_vc_id_o,
  input  logic [N_VIRT_CHN-1:0] fout_ready_i,
  output logic [4:0]            router_port_o,
  output logic                  proto_err_o
);

  localparam logic [0:0] VC_IDLE   = 1'b0;
  localparam logic [0:0] VC_IN_PKT = 1'b1;

  logic [N_VIRT_CHN-1:0] push, pop, full, empty, eligible;
  logic [FLIT_WIDTH-1:0] head_data [N_VIRT_CHN];
  logic [0:0]            vc_state_q [N_VIRT_CHN];
  logic [0:0]            vc_state_d [N_VIRT_CHN];
  router_port_t          route_q [N_VIRT_CHN];
  router_port_t          route_d [N_VIRT_CHN];
  logic [VC_W-1:0]       rr_q, rr_d, grant_idx, cand;
  logic                  grant_vld;

  logic [FLIT_WIDTH-1:0] head;
  flit_type_t            head_type;
  logic                  is_head, seq_err, drop;
  router_port_t          calc_route, out_route;

  for (genvar gi = 0; gi < N_VIRT_CHN; gi++) begin : g_vc
    assign push[gi]     = fin_valid_i && (int'(fin_vc_id_i) == gi) && !full[gi];
    assign pop[gi]      = grant_vld && (int'(grant_idx) == gi);
    assign eligible[gi] = !empty[gi] && fout_ready_i[gi];

    vc_flit_fifo #(
      .WIDTH(FLIT_WIDTH),
      .DEPTH(BUFF_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .arst     (arst),
      .wr_en_i  (push[gi]),
      .wr_data_i(fin_data_i),
      .rd_en_i  (pop[gi]),
      .rd_data_o(head_data[gi]),
      .full_o   (full[gi]),
      .empty_o  (empty[gi])
    );
  end

  assign fin_ready_o = ~full;
  // A valid flit that no FIFO accepted was aimed at a full VC.
  assign drop = fin_valid_i && !(|push);

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < N_VIRT_CHN; i++) begin
      cand = VC_W'((int'(rr_q) + i) % N_VIRT_CHN);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    rr_d = grant_vld ? VC_W'((int'(grant_idx) + 1) % N_VIRT_CHN) : rr_q;
  end

  always_comb begin
    head       = head_data[grant_idx];
    head_type  = flit_type_t'(head[FLIT_WIDTH-1 -: 2]);
    is_head    = (head_type == HEAD_FLIT) || (head_type == HEAD_TAIL_FLIT);
    calc_route = xy_route(head[FLIT_WIDTH-3 -: XWidth],
                          head[FLIT_WIDTH-3-XWidth -: YWidth],
                          XWidth'(ROUTER_X_ID), YWidth'(ROUTER_Y_ID));
    if (is_head)                                 out_route = calc_route;
    else if (vc_state_q[grant_idx] == VC_IN_PKT) out_route = route_q[grant_idx];
    else                                         out_route = PORT_NONE;
    seq_err = grant_vld && (is_head ? (vc_state_q[grant_idx] == VC_IN_PKT)
                                    : (vc_state_q[grant_idx] == VC_IDLE));
  end

  // Packet state follows the popped flit's type, even when the sequence was illegal.
  always_comb begin
    for (int v = 0; v < N_VIRT_CHN; v++) begin
      vc_state_d[v] = vc_state_q[v];
      route_d[v]    = route_q[v];
    end
    if (grant_vld) begin
      case (head_type)
        HEAD_FLIT: begin
          vc_state_d[grant_idx] = VC_IN_PKT;
          route_d[grant_idx]    = calc_route;
        end
        BODY_FLIT: vc_state_d[grant_idx] = VC_IN_PKT;
        default: begin
          vc_state_d[grant_idx] = VC_IDLE;
          route_d[grant_idx]    = PORT_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      rr_q <= '0;
      for (int v = 0; v < N_VIRT_CHN; v++) begin
        vc_state_q[v] <= VC_IDLE;
        route_q[v]    <= PORT_NONE;
      end
    end else begin
      rr_q <= rr_d;
      for (int v = 0; v < N_VIRT_CHN; v++) begin
        vc_state_q[v] <= vc_state_d[v];
        route_q[v]    <= route_d[v];
      end
    end
  end

  assign fout_valid_o  = grant_vld;
  assign fout_data_o   = grant_vld ? head : '0;
  assign fout_vc_id_o  = grant_vld ? grant_idx : '0;
  assign router_port_o = grant_vld ? out_route : PORT_NONE;
  assign proto_err_o   = drop || seq_err;

endmodule

// File: tb/tb_input_module_vc.sv
// Bench for input_module_vc at router (1,1): queue-based model checked every cycle plus directed literal checks.
module tb_input_module_vc;

  localparam int FW = 34;
  localparam int NV = 2;
  localparam int RX = 1;
  localparam int RY = 1;

  logic          clk = 1'b0;
  logic          arst = 1'b0;
  logic          fin_valid_i = 1'b0;
  logic [FW-1:0] fin_data_i = '0;
  logic [0:0]    fin_vc_id_i = '0;
  logic [1:0]    fin_ready_o;
  logic          fout_valid_o;
  logic [FW-1:0] fout_data_o;
  logic [0:0]    fout_vc_id_o;
  logic [1:0]    fout_ready_i = 2'b00;
  logic [4:0]    router_port_o;
  logic          proto_err_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  input_module_vc #(
    .FLIT_WIDTH (FW),
    .N_VIRT_CHN (NV),
    .BUFF_DEPTH (4),
    .ROUTER_X_ID(RX),
    .ROUTER_Y_ID(RY)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .fin_valid_i  (fin_valid_i),
    .fin_data_i   (fin_data_i),
    .fin_vc_id_i  (fin_vc_id_i),
    .fin_ready_o  (fin_ready_o),
    .fout_valid_o (fout_valid_o),
    .fout_data_o  (fout_data_o),
    .fout_vc_id_o (fout_vc_id_o),
    .fout_ready_i (fout_ready_i),
    .router_port_o(router_port_o),
    .proto_err_o  (proto_err_o)
  );

  localparam logic [4:0] P_N = 5'b00001, P_S = 5'b00010, P_W = 5'b00100,
                         P_E = 5'b01000, P_L = 5'b10000, P_0 = 5'b00000;

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int x, input int y, input int p);
    logic [1:0]  xs;
    logic [1:0]  ys;
    logic [27:0] ps;
    xs = x[1:0];
    ys = y[1:0];
    ps = p[27:0];
    return {t, xs, ys, ps};
  endfunction

  function automatic logic [4:0] xy_expect(input int x, input int y);
    if (x > RX) return P_E;
    if (x < RX) return P_W;
    if (y > RY) return P_S;
    if (y < RY) return P_N;
    return P_L;
  endfunction

  // Model: per-VC queues, per-VC packet-open flag with its route, round-robin start point.
  logic [FW-1:0] mq [NV][$];
  bit            m_open [NV];
  logic [4:0]    m_route [NV];
  int            m_rr = 0;

  int            g;
  int            c;
  logic [FW-1:0] f;
  logic [1:0]    ft;
  bit            hd;
  logic [1:0]    e_rdy;
  logic [4:0]    e_port;
  bit            e_err;
  logic [43:0]   exp_v, act_v;

  always @(negedge clk) begin
    act_v = {fout_valid_o, fout_data_o, fout_vc_id_o, router_port_o, proto_err_o, fin_ready_o};
    if (!arst) begin
      for (int v = 0; v < NV; v++) begin
        mq[v].delete();
        m_open[v]  = 1'b0;
        m_route[v] = P_0;
      end
      m_rr  = 0;
      exp_v = {1'b0, 34'h0, 1'b0, 5'b0, 1'b0, 2'b11};
    end else begin
      e_rdy = {mq[1].size() < 4, mq[0].size() < 4};
      g = -1;
      for (int k = 0; k < NV; k++) begin
        c = (m_rr + k) % NV;
        if (g < 0 && mq[c].size() > 0 && fout_ready_i[c]) g = c;
      end
      e_port = P_0;
      e_err  = 1'b0;
      f      = '0;
      if (g >= 0) begin
        f  = mq[g][0];
        ft = f[33:32];
        hd = (ft == 2'b00) || (ft == 2'b11);
        if (hd)             e_port = xy_expect(int'(f[31:30]), int'(f[29:28]));
        else if (m_open[g]) e_port = m_route[g];
        e_err = hd ? m_open[g] : !m_open[g];
      end
      if (fin_valid_i && !e_rdy[fin_vc_id_i]) e_err = 1'b1;
      exp_v = {(g >= 0), f, (g >= 0) ? g[0] : 1'b0, e_port, e_err, e_rdy};
      if (g >= 0) begin
        $display("out t=%0t vc=%0d data=%h port=%b err=%b", $time, g, f, e_port, e_err);
        void'(mq[g].pop_front());
        case (ft)
          2'b00: begin m_open[g] = 1'b1; m_route[g] = e_port; end
          2'b01: m_open[g] = 1'b1;
          default: begin m_open[g] = 1'b0; m_route[g] = P_0; end
        endcase
        m_rr = (g + 1) % NV;
      end
      if (fin_valid_i && e_rdy[fin_vc_id_i]) mq[fin_vc_id_i].push_back(fin_data_i);
    end
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL cycle_cmp t=%0t got v/data/vc/port/err/rdy=%h want=%h", $time, act_v, exp_v);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [0:0] vc, input logic [FW-1:0] d);
    fin_valid_i = 1'b1;
    fin_vc_id_i = vc;
    fin_data_i  = d;
  endtask

  task automatic idle();
    fin_valid_i = 1'b0;
  endtask

  task automatic exp_out(input string nm, input logic v, input logic [0:0] vc,
                         input logic [4:0] p, input logic e);
    #1;
    checks++;
    if ({fout_valid_o, fout_vc_id_o, router_port_o, proto_err_o} !== {v, vc, p, e}) begin
      failures++;
      $display("FAIL %s: got valid=%b vc=%0d port=%b err=%b, want valid=%b vc=%0d port=%b err=%b",
               nm, fout_valid_o, fout_vc_id_o, router_port_o, proto_err_o, v, vc, p, e);
    end
  endtask

  task automatic exp_rdy(input string nm, input logic [1:0] r);
    #1;
    checks++;
    if (fin_ready_o !== r) begin
      failures++;
      $display("FAIL %s: got fin_ready=%b, want %b", nm, fin_ready_o, r);
    end
  endtask

  initial begin
    // Reset, then reset again while VC0 holds two flits.
    tick(); tick();
    arst = 1'b1;
    exp_out("rst_out", 0, 0, P_0, 0); exp_rdy("rst_rdy", 2'b11);
    push(0, mk(2'b00, 3, 1, 1)); tick();
    push(0, mk(2'b01, 0, 0, 2)); tick();
    idle();
    exp_rdy("buf2_rdy", 2'b11);
    arst = 1'b0;
    exp_out("mid_rst_out", 0, 0, P_0, 0); exp_rdy("mid_rst_rdy", 2'b11);
    tick();
    arst = 1'b1; fout_ready_i = 2'b11;
    exp_out("post_rst0", 0, 0, P_0, 0); tick();
    exp_out("post_rst1", 0, 0, P_0, 0); tick();
    exp_out("post_rst2", 0, 0, P_0, 0);

    // HEAD x=3,y=1 + BODY + TAIL on VC0 -> East for all three.
    push(0, mk(2'b00, 3, 1, 16)); exp_out("t2_empty", 0, 0, P_0, 0); tick();
    push(0, mk(2'b01, 0, 0, 17)); exp_out("t2_head", 1, 0, P_E, 0); tick();
    push(0, mk(2'b10, 0, 0, 18)); exp_out("t2_body", 1, 0, P_E, 0); tick();
    idle();                       exp_out("t2_tail", 1, 0, P_E, 0); tick();
    exp_out("t2_done", 0, 0, P_0, 0);

    // HEAD_TAIL to self -> LOCAL; the next HEAD starts a fresh packet (North).
    push(1, mk(2'b11, 1, 1, 32)); tick();
    push(1, mk(2'b00, 1, 0, 33)); exp_out("t5_ht", 1, 1, P_L, 0); tick();
    push(1, mk(2'b10, 0, 0, 34)); exp_out("t5_newhead", 1, 1, P_N, 0); tick();
    idle();                       exp_out("t5_tail", 1, 1, P_N, 0); tick();

    // Fill VC1 with downstream blocked; a 5th flit is dropped with an error pulse.
    fout_ready_i = 2'b00;
    push(1, mk(2'b00, 2, 2, 48)); tick();
    push(1, mk(2'b01, 0, 0, 49)); tick();
    push(1, mk(2'b01, 0, 0, 50)); tick();
    push(1, mk(2'b10, 0, 0, 51)); tick();
    push(1, mk(2'b01, 0, 0, 52));
    exp_out("t3_drop", 0, 0, P_0, 1); exp_rdy("t3_full", 2'b01); tick();
    push(0, mk(2'b11, 0, 1, 64)); exp_out("t3_noerr", 0, 0, P_0, 0); tick();
    push(0, mk(2'b11, 1, 2, 65)); tick();
    idle();

    // Both VCs loaded: alternate 0,1,0,1; then VC0 blocked so only VC1 drains.
    fout_ready_i = 2'b11;
    exp_out("t4_o0", 1, 0, P_W, 0); tick();
    exp_out("t4_o1", 1, 1, P_E, 0); tick();
    exp_out("t4_o2", 1, 0, P_S, 0); tick();
    exp_out("t4_o3", 1, 1, P_E, 0); tick();
    fout_ready_i = 2'b10;
    push(0, mk(2'b11, 1, 1, 66));
    exp_out("t4_vc1a", 1, 1, P_E, 0); tick();
    idle();
    exp_out("t4_vc1b", 1, 1, P_E, 0); tick();
    exp_out("t4_blk", 0, 0, P_0, 0); exp_rdy("t4_rdy", 2'b11); tick();
    fout_ready_i = 2'b11;
    exp_out("t4_vc0", 1, 0, P_L, 0); tick();

    // BODY to an idle VC: forwarded with no route and an error pulse in the pop cycle.
    push(0, mk(2'b01, 0, 0, 80)); exp_out("t6_empty", 0, 0, P_0, 0); tick();
    push(0, mk(2'b10, 0, 0, 81)); exp_out("t6_body", 1, 0, P_0, 1); tick();
    idle();                       exp_out("t6_tail", 1, 0, P_0, 0); tick();
    exp_out("t6_after", 0, 0, P_0, 0); tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
